// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: load-type encodings and field widths.
// No logic, no latency.
// No flow control; constants only.
package mips_pkg;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    // Register-number field width (32 architectural registers)
    localparam int REG_W = 5;

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends the load lane from a data-memory word and flags misalignment.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_dm_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ld_type,
    input  logic        i_memtoreg,
    output logic [31:0] o_ld_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select: byte lane by both address bits, halfword lane by bit 1 (little-endian)
    always_comb begin
        w_byte = i_dm_data[7:0];
        case (i_addr_lo)
            2'b00: w_byte = i_dm_data[7:0];
            2'b01: w_byte = i_dm_data[15:8];
            2'b10: w_byte = i_dm_data[23:16];
            2'b11: w_byte = i_dm_data[31:24];
            default: w_byte = i_dm_data[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_dm_data[31:16] : i_dm_data[15:0];
    end

    // Extension and alignment check; reserved encodings behave as LW.
    // Misalignment only matters when the writeback actually comes from memory.
    always_comb begin
        o_ld_data  = i_dm_data;
        o_misalign = 1'b0;
        case (i_ld_type)
            LD_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU: o_ld_data = {24'h000000, w_byte};
            LD_LH: begin
                o_ld_data  = {{16{w_half[15]}}, w_half};
                o_misalign = i_memtoreg & i_addr_lo[0];
            end
            LD_LHU: begin
                o_ld_data  = {16'h0000, w_half};
                o_misalign = i_memtoreg & i_addr_lo[0];
            end
            default: begin
                o_ld_data  = i_dm_data;
                o_misalign = i_memtoreg & (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: selects ALU/load data, qualifies the RF write, counts retirements.
// One cycle latency: MEM inputs sampled at edge N appear on WB outputs after edge N.
// stall_wb holds all state (beats flush_wb); flush_wb inserts a bubble keeping rw/busW.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_wb,
    input  logic              flush_wb,
    input  logic              valid_me,
    input  logic [31:0]       dm_data_me,
    input  logic [31:0]       Result_me,
    input  logic [REG_W-1:0]  rw_me,
    input  logic              RegWr_me,
    input  logic              MemtoReg_me,
    input  logic [2:0]        ld_type_me,
    output logic              valid_wb,
    output logic              RegWr_wb,
    output logic [REG_W-1:0]  rw_wb,
    output logic [31:0]       busW_wb,
    output logic              misalign_wb,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [31:0]      w_ld_data;
    logic             w_misalign_raw;
    logic             w_misalign;
    logic [31:0]      w_busw;
    logic             w_regwr;
    logic             w_retire;

    logic             r_valid;
    logic             r_regwr;
    logic [REG_W-1:0] r_rw;
    logic [31:0]      r_busw;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    load_align u_load_align (
        .i_dm_data  (dm_data_me),
        .i_addr_lo  (Result_me[1:0]),
        .i_ld_type  (ld_type_me),
        .i_memtoreg (MemtoReg_me),
        .o_ld_data  (w_ld_data),
        .o_misalign (w_misalign_raw)
    );

    // Writeback data select and qualification; a misaligned load writes nothing and is not retired
    always_comb begin
        w_misalign = w_misalign_raw & valid_me;
        w_busw     = MemtoReg_me ? w_ld_data : Result_me;
        if (w_misalign) begin
            w_busw = 32'h0000_0000;
        end
        w_regwr  = RegWr_me & valid_me & ~w_misalign & (rw_me != '0);
        w_retire = valid_me & ~w_misalign;
    end

    // Pipeline register with reset > stall > flush > load priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwr    <= 1'b0;
            r_rw       <= '0;
            r_busw     <= 32'h0000_0000;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (stall_wb) begin
            r_valid    <= r_valid;
            r_regwr    <= r_regwr;
            r_rw       <= r_rw;
            r_busw     <= r_busw;
            r_misalign <= r_misalign;
            r_cnt      <= r_cnt;
        end else if (flush_wb) begin
            r_valid    <= 1'b0;
            r_regwr    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_valid    <= valid_me;
            r_regwr    <= w_regwr;
            r_rw       <= rw_me;
            r_busw     <= w_busw;
            r_misalign <= w_misalign;
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign valid_wb    = r_valid;
    assign RegWr_wb    = r_regwr;
    assign rw_wb       = r_rw;
    assign busW_wb     = r_busw;
    assign misalign_wb = r_misalign;
    assign retire_cnt  = r_cnt;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the data memory (MEM) stage and register-file writeback (WB) in the 5-stage MIPS core.
- Selects ALU result or load data, extracts and sign/zero-extends byte/halfword loads, and flags misaligned loads.
- Supports stall and flush, and keeps a retired-instruction counter.
- Outputs drive the register-file write port and the WB forwarding path.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_wb  in  1  hold all WB registers and counter
- flush_wb  in  1  load a bubble into WB
- valid_me  in  1  MEM-stage instruction valid
- dm_data_me  in  32  word read from data memory at Result_me[11:2]
- Result_me  in  32  ALU result / effective address
- rw_me  in  5  destination register number
- RegWr_me  in  1  instruction writes a register
- MemtoReg_me  in  1  1 = writeback from load data, 0 = from Result_me
- ld_type_me  in  3  load type: LW/LB/LBU/LH/LHU
- valid_wb  out  1  WB instruction valid
- RegWr_wb  out  1  register-file write enable (qualified)
- rw_wb  out  5  register-file write address
- busW_wb  out  32  register-file write data
- misalign_wb  out  1  WB instruction was a misaligned load
- retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: valid_wb, RegWr_wb, misalign_wb = 0; rw_wb = 0; busW_wb = 0; retire_cnt = 0.
- Latency: one cycle. MEM inputs at edge N appear on the WB outputs after edge N.
- Per-edge priority:
  - rst: clear everything.
  - else stall_wb=1: hold all registers, including retire_cnt. Stall beats flush.
  - else flush_wb=1: valid_wb=0, RegWr_wb=0, misalign_wb=0. rw_wb and busW_wb hold their previous values. No count.
  - else: load from MEM.
- Data select when MemtoReg_me=0: busW = Result_me; ld_type_me is ignored and misalign = 0.
- Data select when MemtoReg_me=1 (a = Result_me[1:0], little-endian lanes):
  - LW: whole word. Misaligned if a != 00.
  - LB/LBU: byte lane a (00 = [7:0], 01 = [15:8], 10 = [23:16], 11 = [31:24]). LB sign-extends, LBU zero-extends. Never misaligned.
  - LH/LHU: a[1]=0 selects [15:0], a[1]=1 selects [31:16]. LH sign-extends, LHU zero-extends. Misaligned if a[0]=1.
  - Reserved ld_type encodings are treated as LW.
- Misaligned load:
  - busW_wb = 0, RegWr_wb = 0, misalign_wb = 1, valid_wb = valid_me. Not counted.
  - misalign_wb is asserted only when valid_me=1.
- RegWr_wb = RegWr_me & valid_me & ~misalign & (rw_me != 0). Register $0 is never written.
- valid_me=0 (bubble from MEM): valid_wb = 0 and RegWr_wb = 0. busW_wb and rw_wb still load, as don't-care values.
- retire_cnt increments by 1 on each normal load edge where valid_me=1 and the instruction is not misaligned. It wraps from all-ones to 0 without any flag.
- Reset mid-stall or mid-flush: reset wins and all state clears on that edge.

Decomposition:
- Shared package (mips_pkg) holds:
  - LD_LW=3'b000, LD_LB=3'b001, LD_LBU=3'b010, LD_LH=3'b011, LD_LHU=3'b100.
  - A width constant for the register-number field (5).
- One combinational sub-module, load_align, computes the extended data and the misalign flag from (dm_data_me, Result_me[1:0], ld_type_me, MemtoReg_me).
- mem_wb_stage holds the registers, the stall/flush priority logic and the counter.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_me=1 → all outputs 0 and retire_cnt=0. After release, one valid ALU op with Result_me=0x1234_5678, rw_me=8 → next cycle busW_wb=0x1234_5678, RegWr_wb=1, rw_wb=8, retire_cnt=1.
- Byte/half extraction with dm_data_me=0x80F1_7F02:
  - LB, a=01 → 0x0000_007F.
  - LB, a=11 → 0xFFFF_FF80.
  - LBU, a=10 → 0x0000_00F1.
  - LH, a=10 → 0xFFFF_80F1.
  - LHU, a=00 → 0x0000_7F02.
- Misalign:
  - LW at Result_me=0x0000_0006 → misalign_wb=1, RegWr_wb=0, busW_wb=0, retire_cnt unchanged.
  - LH at a=01 → misalign_wb=1.
  - LB at a=01 → no misalign.
- Stall/flush:
  - Hold stall_wb=1 for 3 cycles while the inputs change → outputs and retire_cnt frozen.
  - stall_wb=1 and flush_wb=1 together → hold.
  - flush_wb=1 alone → valid_wb=0, RegWr_wb=0, no count.
- $0 guard: valid write with rw_me=0, RegWr_me=1 → RegWr_wb=0, valid_wb=1, retire_cnt increments.
- Wrap: with CNT_W=4, retire 17 valid instructions → retire_cnt=1.
